// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle processor: datapath widths,
// PCSource encodings and the fetch-stage state type.
package cpu_pkg;

  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned TIMER_W  = 8;

  typedef enum logic [1:0] {
    PCSRC_SEQ  = 2'd0,
    PCSRC_BR   = 2'd1,
    PCSRC_JMP  = 2'd2,
    PCSRC_HOLD = 2'd3
  } pc_src_e;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_REQ,
    FS_DONE
  } fetch_state_e;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection and sequential PC+PC_STEP adder (wraps mod 2^ADDR_W).
module pc_next_mux #(
  parameter int unsigned ADDR_W  = cpu_pkg::ADDR_W,
  parameter int unsigned PC_STEP = 2
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_write_i,
  input  logic [1:0]        pc_source_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  output logic [ADDR_W-1:0] pc_next_o,
  output logic [ADDR_W-1:0] pc_plus_o
);
  import cpu_pkg::*;

  assign pc_plus_o = pc_i + ADDR_W'(PC_STEP);

  always_comb begin
    pc_next_o = pc_i;
    if (pc_write_i) begin
      case (pc_src_e'(pc_source_i))
        PCSRC_SEQ:  pc_next_o = pc_plus_o;
        PCSRC_BR:   pc_next_o = branch_target_i;
        PCSRC_JMP:  pc_next_o = jump_target_i;
        default:    pc_next_o = pc_i;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC and IR, runs a req/ack read of instruction memory
// on IRWrite and presents the opcode field to the control unit.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W   = cpu_pkg::ADDR_W,
  parameter int unsigned INSTR_W  = cpu_pkg::INSTR_W,
  parameter int unsigned OPCODE_W = cpu_pkg::OPCODE_W,
  parameter int unsigned PC_STEP  = 2,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                IRWrite,
  input  logic                PCWrite,
  input  logic [1:0]          PCSource,
  input  logic [ADDR_W-1:0]   BranchTarget,
  input  logic [ADDR_W-1:0]   JumpTarget,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [INSTR_W-1:0]  mem_rdata,
  input  logic                mem_ack,
  output logic [ADDR_W-1:0]   PC,
  output logic [ADDR_W-1:0]   PCPlus,
  output logic [INSTR_W-1:0]  IR,
  output logic [OPCODE_W-1:0] Opcode,
  output logic                InstrValid,
  output logic                FetchBusy,
  output logic                FetchErr
);
  import cpu_pkg::*;

  fetch_state_e         state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic                 mem_req_q, mem_req_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 err_q, err_d;

  pc_next_mux #(
    .ADDR_W  (ADDR_W),
    .PC_STEP (PC_STEP)
  ) u_pc_next_mux (
    .pc_i            (pc_q),
    .pc_write_i      (PCWrite),
    .pc_source_i     (PCSource),
    .branch_target_i (BranchTarget),
    .jump_target_i   (JumpTarget),
    .pc_next_o       (pc_d),
    .pc_plus_o       (PCPlus)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q    <= FS_IDLE;
      pc_q       <= ADDR_W'(RESET_PC);
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
      ir_q       <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      ir_q       <= ir_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
    end
  end

  // DONE accepts a new IRWrite exactly like IDLE so fetches can run back-to-back.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = mem_req_q;
    ir_d       = ir_q;
    timer_d    = timer_q;
    err_d      = err_q;
    case (state_q)
      FS_IDLE, FS_DONE: begin
        state_d = FS_IDLE;
        if (IRWrite) begin
          mem_addr_d = pc_q;
          mem_req_d  = 1'b1;
          timer_d    = '0;
          state_d    = FS_REQ;
        end
      end
      FS_REQ: begin
        if (IRWrite) begin
          err_d = 1'b1;
        end
        if (mem_ack) begin
          ir_d      = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = FS_DONE;
        end else if (timer_q == TIMER_W'(TIMEOUT)) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = FS_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d   = FS_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign PC         = pc_q;
  assign IR         = ir_q;
  assign Opcode     = ir_q[INSTR_W-1 -: OPCODE_W];
  assign InstrValid = (state_q == FS_DONE);
  assign FetchBusy  = (state_q == FS_REQ);
  assign FetchErr   = err_q;

endmodule
